// File: rtl/exe_pkg.sv
// exe_pkg: opcode encodings and sequencer state shared by exe_engine and instr_sequencer
package exe_pkg;
    localparam int INSTR_W = 5;
    localparam logic [INSTR_W-1:0] OP_NOP  = 5'b00000;
    localparam logic [INSTR_W-1:0] OP_HALT = 5'b11111;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MEMWAIT,
        S_ISSUE,
        S_EXEC,
        S_HALTED
    } seq_state_e;
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches opcodes from a synchronous memory and issues them to exe_engine one at a time
module instr_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = exe_pkg::INSTR_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exe_done,
    output logic               busy,
    output logic               halted,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   issue_count
);
    import exe_pkg::seq_state_e, exe_pkg::S_IDLE, exe_pkg::S_FETCH, exe_pkg::S_MEMWAIT;
    import exe_pkg::S_ISSUE, exe_pkg::S_EXEC, exe_pkg::S_HALTED;

    localparam logic [INSTR_W-1:0] HALT = INSTR_W'(exe_pkg::OP_HALT);
    localparam logic [INSTR_W-1:0] NOP  = INSTR_W'(exe_pkg::OP_NOP);

    seq_state_e state, state_d;
    logic       launch, load, running, last;

    assign launch  = (state == S_IDLE || state == S_HALTED) && start;
    assign load    = state == S_MEMWAIT && mem_rdata != HALT;
    assign running = (state == S_ISSUE || state == S_EXEC) && exe_done;
    assign last    = pc == '1;

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE, S_HALTED: state_d = start ? S_FETCH : state;
            S_FETCH:          state_d = S_MEMWAIT;
            S_MEMWAIT:        state_d = load ? S_ISSUE : S_HALTED;
            S_ISSUE, S_EXEC:  state_d = !exe_done ? S_EXEC : (last ? S_HALTED : S_FETCH);
            default:          state_d = S_IDLE;
        endcase
    end

    // The count is bumped on entry to ISSUE so it already includes the opcode being pulsed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            issue_count <= '0;
            instr       <= NOP;
        end else begin
            state <= state_d;
            if (launch) begin
                pc          <= '0;
                issue_count <= '0;
            end else if (running && !last) begin
                pc <= pc + 1'b1;
            end
            if (load) begin
                instr <= mem_rdata;
                if (issue_count != '1)
                    issue_count <= issue_count + 1'b1;
            end
        end
    end

    assign mem_rd_en   = state == S_FETCH;
    assign mem_addr    = pc;
    assign instr_valid = state == S_ISSUE;
    assign busy        = state == S_FETCH || state == S_MEMWAIT || state == S_ISSUE || state == S_EXEC;
    assign halted      = state == S_HALTED;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized programs checked against a transaction-level model of the sequencer
module tb_instr_sequencer;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0, exe_done = 1'b0;
    logic       mem_rd_en, instr_valid, busy, halted;
    logic [7:0] mem_addr, pc;
    logic [4:0] mem_rdata = '0, instr;
    logic [15:0] issue_count;
    logic [4:0] mem [256];
    logic [4:0] last_instr = '0;

    logic       start_s = 1'b0, rd_s, valid_s, busy_s, halted_s;
    logic [3:0] addr_s, pc_s;
    logic [4:0] rdata_s = '0, instr_s;
    logic [2:0] cnt_s;

    int checks = 0, errors = 0;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid), .exe_done(exe_done),
        .busy(busy), .halted(halted), .pc(pc), .issue_count(issue_count)
    );

    instr_sequencer #(.ADDR_W(4), .CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .mem_rd_en(rd_s), .mem_addr(addr_s),
        .mem_rdata(rdata_s), .instr(instr_s), .instr_valid(valid_s), .exe_done(1'b1),
        .busy(busy_s), .halted(halted_s), .pc(pc_s), .issue_count(cnt_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
    always @(posedge clk) if (rd_s) rdata_s <= 5'b00001;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(int h);
        for (int i = 0; i < 256; i++) mem[i] = 5'($urandom_range(0, 30));
        if (h < 256) mem[h] = 5'b11111;
    endtask

    // Caller is on a negedge in IDLE or HALTED. Runs until the program halts at word h (256 = none).
    task automatic run(int h, int max_stall);
        start = 1'b1;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            check("fetch", {mem_rd_en, busy, halted, instr_valid, mem_addr}, {4'b1100, 8'(k)});
            start = 1'($urandom);
            exe_done = 1'($urandom);
            @(negedge clk);
            check("memwait", {mem_rd_en, busy, instr_valid, pc}, {3'b010, 8'(k)});
            start = 1'($urandom);
            exe_done = 1'($urandom);
            @(negedge clk);
            if (k == h) begin
                check("halt_op", {halted, busy, instr_valid, instr}, {3'b100, last_instr});
                check("halt_pc", {mem_addr, pc, issue_count}, {8'(k), 8'(k), 16'(k)});
                start = 1'b0;
                exe_done = 1'($urandom);
                return;
            end
            check("issue", {instr_valid, busy, instr, pc}, {2'b11, mem[k], 8'(k)});
            check("issue_cnt", issue_count, k + 1);
            last_instr = mem[k];
            begin
                int d = $urandom_range(0, max_stall);
                start = 1'($urandom);
                exe_done = d == 0;
                for (int j = 0; j < d; j++) begin
                    @(negedge clk);
                    check("exec", {instr_valid, busy, instr, pc}, {2'b01, mem[k], 8'(k)});
                    start = 1'($urandom);
                    exe_done = j == d - 1;
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        exe_done = 1'($urandom);
        check("end_mem", {halted, busy, instr, pc}, {2'b10, last_instr, 8'd255});
        check("end_cnt", issue_count, 256);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", {mem_rd_en, instr_valid, busy, halted, instr, mem_addr, pc, issue_count}, '0);
        reset = 1'b1;
        @(negedge clk);

        fill(256);
        mem[0] = 5'b00001;
        mem[1] = 5'b00010;
        mem[2] = 5'b11111;
        run(2, 0);
        repeat (3) @(negedge clk);
        check("halt_hold", {halted, instr, pc, issue_count}, {1'b1, 5'b00010, 8'd2, 16'd2});

        for (int t = 0; t < 8; t++) begin
            int h = $urandom_range(0, 20);
            fill(h);
            run(h, 4);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        fill(256);
        run(256, 1);

        fill(10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exe_done = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset", {busy, instr_valid, instr}, {2'b10, mem[0]});
        #2 reset = 1'b0;
        #1 check("async_reset", {mem_rd_en, instr_valid, busy, halted, instr, mem_addr, pc, issue_count}, '0);
        @(negedge clk);
        reset = 1'b1;
        last_instr = '0;
        @(negedge clk);
        run(10, 2);

        begin
            int n = 0;
            start_s = 1'b1;
            @(negedge clk);
            start_s = 1'b0;
            for (int c = 0; c < 100 && !halted_s; c++) begin
                @(negedge clk);
                if (valid_s) begin
                    n++;
                    check("sat_cnt", cnt_s, n > 7 ? 7 : n);
                end
            end
            check("sat_end", {halted_s, pc_s, cnt_s, 8'(n)}, {1'b1, 4'd15, 3'd7, 8'd16});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer that sits in front of `exe_engine` and drives its 5-bit `instr` input. It fetches opcodes from a synchronous instruction memory, issues them one at a time, and waits for the execution units to report completion before it advances. A HALT opcode or the end of memory stops it. It replaces the free-running instruction stimulus with a handshaked producer.

## Interface

Parameters:

- `ADDR_W`, default 8: instruction memory address width.
- `INSTR_W`, default 5: opcode width. Must match `exe_engine`.
- `CNT_W`, default 16: width of the issued-instruction counter.

Ports:

- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin execution from address 0. Level-sampled.
- `mem_rd_en`  out  1: instruction memory read strobe.
- `mem_addr`  out  ADDR_W: instruction memory address; always equals `pc`.
- `mem_rdata`  in  INSTR_W: read data, valid the cycle after `mem_rd_en`.
- `instr`  out  INSTR_W: opcode to `exe_engine`. Registered and held stable until the next issue.
- `instr_valid`  out  1: one-cycle pulse marking a new opcode on `instr`.
- `exe_done`  in  1: execution units have finished the current opcode.
- `busy`  out  1: high in FETCH, MEMWAIT, ISSUE and EXEC.
- `halted`  out  1: high in HALTED.
- `pc`  out  ADDR_W: current fetch address.
- `issue_count`  out  CNT_W: number of opcodes issued since start. Saturates at all-ones.

## Operation

- **States:** IDLE, FETCH, MEMWAIT, ISSUE, EXEC, HALTED.
- **IDLE**
  - `instr` = NOP (00000), `pc` = 0.
  - `start` = 1 → FETCH and clear `issue_count`.
- **FETCH**
  - `mem_rd_en` = 1 → MEMWAIT.
- **MEMWAIT**
  - `mem_rdata` is valid in this cycle.
  - If `mem_rdata` == HALT (11111): → HALTED; `instr` stays at its previous value and is not issued.
  - Otherwise: `instr` <= `mem_rdata`, → ISSUE.
- **ISSUE**
  - `instr_valid` = 1 and `issue_count` increments.
  - `exe_done` = 1 in the same cycle → ADVANCE.
  - Otherwise → EXEC.
- **EXEC**
  - `instr_valid` = 0 and `instr` is held.
  - `exe_done` = 1 → ADVANCE.
- **ADVANCE** (an action on the transition, not a state)
  - If `pc` == 2^ADDR_W−1: → HALTED, `pc` unchanged. The PC never wraps.
  - Otherwise: `pc` <= `pc` + 1, → FETCH.
- **HALTED**
  - `instr` is held.
  - `start` = 1 → FETCH with `pc` = 0 and `issue_count` cleared.
- **Ignored inputs**
  - `exe_done` is ignored in IDLE, FETCH, MEMWAIT and HALTED.
  - `start` is ignored while `busy`.
- **Counter:** `issue_count` increments once per ISSUE cycle and saturates at 2^CNT_W−1.

## Timing

- **Reset values:** all outputs are 0 (`instr` = 00000, `instr_valid` = 0, `mem_rd_en` = 0, `mem_addr` = 0, `busy` = 0, `halted` = 0, `pc` = 0, `issue_count` = 0). The state is IDLE.
- **Reset timing:** asserting `reset` takes effect immediately, independent of `clk`, in any state including mid-EXEC. Deassertion is synchronised by the register clocking. The first `start` is sampled at the first rising edge after deassertion.
- **Start-to-first-issue latency:** with `start` sampled at edge N, FETCH is cycle N+1, MEMWAIT is N+2, and ISSUE is N+3 (`instr` and `instr_valid` update at edge N+3).
- **Throughput:** with `exe_done` tied high, each opcode takes 3 cycles (FETCH, MEMWAIT, ISSUE).
- **Hold time of `instr`:** each extra cycle `exe_done` stays low adds one EXEC cycle, and `instr` holds throughout.
- **Outputs:** all outputs are registered or decoded from the state register only. No input-to-output combinational paths.

## Structure

- Shared package `exe_pkg` contains:
  - `INSTR_W`;
  - opcode constants `OP_NOP` = 5'b00000 and `OP_HALT` = 5'b11111;
  - the sequencer state enum.
- `exe_engine` imports the same package, so the opcode encodings have a single source.
- The design is a single flat module with no sub-modules. The FSM, PC and saturating counter are too small to split.

## Test plan

- **Basic program:** memory holds [00001, 00010, 11111], `exe_done` is tied high, `start` is pulsed at edge 0.
  - `instr` = 00001 with a `instr_valid` pulse at edge 3.
  - `instr` = 00010 with a pulse at edge 6.
  - `halted` = 1 at edge 9, `instr` still 00010, `issue_count` = 2, `pc` = 2.
- **Stall:** `exe_done` held low for 4 cycles after ISSUE.
  - `instr_valid` pulses exactly once.
  - `instr` is stable for 5 cycles.
  - FETCH of the next address occurs the cycle after `exe_done`.
- **End of memory:** ADDR_W = 8, all 256 words = 00001, `exe_done` high.
  - Sequencer halts after 256 issues with `pc` = 255 and `issue_count` = 256.
  - `mem_addr` never shows 0 after the first fetch.
- **Reset mid-operation:** drive `reset` low during EXEC, between clock edges.
  - All outputs go to 0 and the state goes to IDLE immediately, without waiting for a clock edge.
  - After release and `start`, the sequencer refetches address 0.
- **Start handling:**
  - `start` held high while `busy` → no restart, `pc` continues incrementing.
  - `start` while HALTED → `pc` = 0, `issue_count` = 0, new fetch from address 0.
- **Spurious done:** `exe_done` = 1 in IDLE, FETCH and MEMWAIT → no state advance and no change to `pc`.
